// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO with fill level, programmable almost-full/almost-empty thresholds,
// overflow/underflow pulses and a selectable registered or first-word-fall-through read port.
module sync_fifo_lvl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AF_LVL = DEPTH - 1,
    parameter int unsigned AE_LVL = 1,
    parameter int unsigned FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         data_wr,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_rd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   AF_C     = (AW + 1)'(AF_LVL);
    localparam logic [AW:0]   AE_C     = (AW + 1)'(AE_LVL);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_idx;
    logic [AW-1:0]    r_rd_idx;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [AW-1:0]    w_wr_idx_nxt;
    logic [AW-1:0]    w_rd_idx_nxt;
    logic [AW:0]      w_count_nxt;

    assign w_full    = (r_count == DEPTH_C);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = pop & ~w_empty & ~flush;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
    assign w_push_ok = push & ~flush & (~w_full | w_pop_ok);

    always_comb begin
        w_wr_idx_nxt = (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + 1'b1;
        w_rd_idx_nxt = (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + 1'b1;
        w_count_nxt  = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_idx <= w_wr_idx_nxt;
            if (w_pop_ok)  r_rd_idx <= w_rd_idx_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= push & ~w_push_ok;
            r_udf   <= pop & w_empty;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once the indices clear.
    always_ff @(posedge clk) begin
        if (rst_n && w_push_ok) begin
            r_mem[r_wr_idx] <= data_wr;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_rd = r_mem[r_rd_idx];
    end else begin : g_reg
        logic [WIDTH-1:0] r_data_rd;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data_rd <= '0;
            end else if (w_pop_ok) begin
                r_data_rd <= r_mem[r_rd_idx];
            end
        end
        assign data_rd = r_data_rd;
    end

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
